// File: rtl/ex_sequencer.sv
// Execute-stage sequencer: holds issued operands for the execution unit, waits
// out the op latency, then presents a writeback. Optional counters: EX_SEQ_PERF_EN.
module ex_sequencer #(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [63:0] in_op1,
   input  logic [63:0] in_op2,
   input  logic [7:0]  in_pc,
   input  logic [7:0]  in_addr,
   input  logic [3:0]  in_rd,
   input  logic        in_flag,
   input  logic        flush,
   output logic [2:0]  eu_op,
   output logic [63:0] eu_op1,
   output logic [63:0] eu_op2,
   output logic [7:0]  eu_pc,
   output logic [7:0]  eu_addr,
   output logic [3:0]  eu_rd,
   input  logic [63:0] eu_value,
   input  logic [7:0]  eu_branch_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] wb_value,
   output logic [3:0]  wb_rd,
   output logic [7:0]  wb_addr,
   output logic [1:0]  wb_ctrl,
   output logic        redirect_valid,
   output logic [7:0]  redirect_pc,
   output logic [31:0] perf_busy,
   output logic [31:0] perf_stall
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [2:0]       OP_MUL  = 3'b010;
   localparam logic [2:0]       OP_BR   = 3'b111;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [63:0]      op1_q, op1_d, op2_q, op2_d;
   logic [7:0]       pc_q, pc_d, addr_q, addr_d;
   logic [3:0]       rd_q, rd_d;
   logic             flag_q, flag_d;
   logic [63:0]      wb_value_q, wb_value_d;
   logic [3:0]       wb_rd_q, wb_rd_d;
   logic [7:0]       wb_addr_q, wb_addr_d;
   logic [1:0]       wb_ctrl_q, wb_ctrl_d;
   logic             rdr_v_q, rdr_v_d;
   logic [7:0]       rdr_pc_q, rdr_pc_d;
   logic             accept, is_ctl;

   // Branches and nops carry no result; they write back a zero value and ctrl.
   assign is_ctl = (op_q == OP_BR) || (op_q == 3'b000) || (op_q == 3'b101);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      rd_d       = rd_q;
      flag_d     = flag_q;
      wb_value_d = wb_value_q;
      wb_rd_d    = wb_rd_q;
      wb_addr_d  = wb_addr_q;
      wb_ctrl_d  = wb_ctrl_q;
      rdr_v_d    = 1'b0;
      rdr_pc_d   = rdr_pc_q;
      in_ready   = rst_n && !flush &&
                   ((state_q == IDLE) || ((state_q == DONE) && out_ready));
      accept     = in_valid && in_ready;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            EXEC: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  wb_value_d = is_ctl ? 64'd0 : eu_value;
                  wb_rd_d    = rd_q;
                  wb_addr_d  = addr_q;
                  wb_ctrl_d  = is_ctl ? 2'b00 : op_q[1:0];
                  if ((op_q == OP_BR) && flag_q) begin
                     rdr_v_d  = 1'b1;
                     rdr_pc_d = eu_branch_pc;
                  end
                  state_d = DONE;
               end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: ;
         endcase
         // A DONE-state accept overrides the return to IDLE (back-to-back issue).
         if (accept) begin
            op_d    = in_op;
            op1_d   = in_op1;
            op2_d   = in_op2;
            pc_d    = in_pc;
            addr_d  = in_addr;
            rd_d    = in_rd;
            flag_d  = in_flag;
            cnt_d   = (in_op == OP_MUL) ? MUL_CNT : '0;
            state_d = EXEC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         pc_q       <= '0;
         addr_q     <= '0;
         rd_q       <= '0;
         flag_q     <= 1'b0;
         wb_value_q <= '0;
         wb_rd_q    <= '0;
         wb_addr_q  <= '0;
         wb_ctrl_q  <= '0;
         rdr_v_q    <= 1'b0;
         rdr_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         flag_q     <= flag_d;
         wb_value_q <= wb_value_d;
         wb_rd_q    <= wb_rd_d;
         wb_addr_q  <= wb_addr_d;
         wb_ctrl_q  <= wb_ctrl_d;
         rdr_v_q    <= rdr_v_d;
         rdr_pc_q   <= rdr_pc_d;
      end
   end

   assign eu_op          = op_q;
   assign eu_op1         = op1_q;
   assign eu_op2         = op2_q;
   assign eu_pc          = pc_q;
   assign eu_addr        = addr_q;
   assign eu_rd          = rd_q;
   assign out_valid      = (state_q == DONE);
   assign wb_value       = wb_value_q;
   assign wb_rd          = wb_rd_q;
   assign wb_addr        = wb_addr_q;
   assign wb_ctrl        = wb_ctrl_q;
   assign redirect_valid = rdr_v_q;
   assign redirect_pc    = rdr_pc_q;

`ifdef EX_SEQ_PERF_EN
   logic [31:0] busy_q, stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q  <= '0;
         stall_q <= '0;
      end else begin
         if ((state_q != IDLE) && (busy_q != '1)) busy_q <= busy_q + 32'd1;
         if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_busy  = busy_q;
   assign perf_stall = stall_q;
`else
   assign perf_busy  = '0;
   assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ex_sequencer.sv
// Self-checking bench for ex_sequencer: directed latency/flush/reset cases plus
// a scoreboard of expected writebacks popped on each out_valid/out_ready handshake.
module tb_ex_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_flag, flush;
   logic [2:0]  in_op, eu_op;
   logic [63:0] in_op1, in_op2, eu_op1, eu_op2, eu_value, wb_value;
   logic [7:0]  in_pc, in_addr, eu_pc, eu_addr, eu_branch_pc, wb_addr, redirect_pc;
   logic [3:0]  in_rd, eu_rd, wb_rd;
   logic        out_valid, out_ready, redirect_valid;
   logic [1:0]  wb_ctrl;
   logic [31:0] perf_busy, perf_stall;

   typedef struct packed {
      logic [63:0] v;
      logic [3:0]  rd;
      logic [7:0]  addr;
      logic [1:0]  ctrl;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_err = 0, rcnt = 0, exp_rcnt = 0;

   ex_sequencer #(.MUL_LAT(3), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .in_pc(in_pc),
      .in_addr(in_addr), .in_rd(in_rd), .in_flag(in_flag), .flush(flush),
      .eu_op(eu_op), .eu_op1(eu_op1), .eu_op2(eu_op2), .eu_pc(eu_pc),
      .eu_addr(eu_addr), .eu_rd(eu_rd), .eu_value(eu_value),
      .eu_branch_pc(eu_branch_pc), .out_valid(out_valid), .out_ready(out_ready),
      .wb_value(wb_value), .wb_rd(wb_rd), .wb_addr(wb_addr), .wb_ctrl(wb_ctrl),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .perf_busy(perf_busy), .perf_stall(perf_stall)
   );

   always #5 clk = ~clk;

   // Execution-unit stand-in driven from the held operands.
   always_comb begin
      case (eu_op)
         3'b001:  eu_value = eu_op1 + eu_op2;
         3'b010:  eu_value = eu_op1 * eu_op2;
         3'b100:  eu_value = eu_op1 ^ eu_op2;
         3'b011:  eu_value = eu_op1 + 64'd1;
         3'b110:  eu_value = {63'd0, eu_op1 < eu_op2};
         default: eu_value = 64'hDEAD_BEEF_0BAD_F00D;
      endcase
      eu_branch_pc = eu_pc + eu_addr;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_wb(input logic [2:0] op, input logic [63:0] a, b,
                                      input logic [7:0] addr, input logic [3:0] rd);
      exp_t e;
      e.rd = rd;
      e.addr = addr;
      case (op)
         3'b001:  begin e.v = a + b;             e.ctrl = 2'b01; end
         3'b010:  begin e.v = a * b;             e.ctrl = 2'b10; end
         3'b100:  begin e.v = a ^ b;             e.ctrl = 2'b00; end
         3'b011:  begin e.v = a + 64'd1;         e.ctrl = 2'b11; end
         3'b110:  begin e.v = {63'd0, a < b};    e.ctrl = 2'b10; end
         default: begin e.v = 64'd0;             e.ctrl = 2'b00; end
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_spurious", 64'd1, 64'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_value", wb_value, e.v);
            chk("sb_tag", {50'd0, wb_rd, wb_addr, wb_ctrl}, {50'd0, e.rd, e.addr, e.ctrl});
         end
      end
      if (redirect_valid) rcnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns 1 ns after the accept edge with in_valid dropped.
   task automatic issue(input logic [2:0] op, input logic [63:0] a, b,
                        input logic [7:0] pc, addr, input logic [3:0] rd,
                        input logic fl, input bit push);
      bit ok = 0;
      in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b;
      in_pc = pc; in_addr = addr; in_rd = rd; in_flag = fl;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk("issue_timeout", 64'd0, 64'd1);
      if (push) begin
         sb.push_back(expect_wb(op, a, b, addr, rd));
         if (op == 3'b111 && fl) exp_rcnt++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 0; in_valid = 0; in_op = 0; in_op1 = 0; in_op2 = 0; in_pc = 0;
      in_addr = 0; in_rd = 0; in_flag = 0; flush = 0; out_ready = 1;
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_eu_op1", eu_op1, 0);
      chk("rst_wb_value", wb_value, 0);
      chk("rst_perf_busy", perf_busy, 0);
      rst_n = 1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      tick();

      // add: result one edge after accept
      issue(3'b001, 64'd5, 64'd7, 8'h00, 8'h21, 4'd2, 1'b0, 1);
      chk("add_exec", out_valid, 0);
      tick();
      chk("add_valid", out_valid, 1);
      chk("add_value", wb_value, 64'd12);
      chk("add_ctrl", wb_ctrl, 2'b01);
      tick();

      // mul: operands held, result three edges after accept
      issue(3'b010, 64'd6, 64'd7, 8'h00, 8'h30, 4'd5, 1'b0, 1);
      for (int k = 0; k < 3; k++) begin
         chk("mul_wait", out_valid, 0);
         chk("mul_op1", eu_op1, 64'd6);
         chk("mul_op2", eu_op2, 64'd7);
         tick();
      end
      chk("mul_valid", out_valid, 1);
      chk("mul_value", wb_value, 64'd42);
      tick();

      // backpressure then back-to-back accept
      out_ready = 0;
      issue(3'b100, 64'hF0, 64'h0F, 8'h00, 8'h11, 4'd7, 1'b0, 1);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_value", wb_value, 64'hFF);
         chk("bp_in_ready", in_ready, 0);
         tick();
      end
`ifdef EX_SEQ_PERF_EN
      chk("perf_stall", perf_stall, 32'd4);
`else
      chk("perf_stall", perf_stall, 32'd0);
      chk("perf_busy", perf_busy, 32'd0);
`endif
      out_ready = 1;
      issue(3'b011, 64'd99, 64'd0, 8'h00, 8'h12, 4'd8, 1'b0, 1);
      chk("b2b_exec", out_valid, 0);
      chk("b2b_op1", eu_op1, 64'd99);
      tick();
      chk("b2b_valid", out_valid, 1);
      tick();

      // taken branch: single-cycle redirect
      issue(3'b111, 64'd1, 64'd2, 8'h10, 8'h04, 4'd3, 1'b1, 1);
      chk("br_pre", redirect_valid, 0);
      tick();
      chk("br_redir", redirect_valid, 1);
      chk("br_pc", redirect_pc, 8'h14);
      chk("br_ctrl", wb_ctrl, 2'b00);
      tick();
      chk("br_pulse", redirect_valid, 0);
      issue(3'b111, 64'd1, 64'd2, 8'h10, 8'h04, 4'd3, 1'b0, 1);
      tick();
      chk("brnt_redir", redirect_valid, 0);
      chk("brnt_value", wb_value, 64'd0);
      tick();

      // flush in the second mul cycle with a competing issue
      issue(3'b010, 64'd9, 64'd3, 8'h00, 8'h40, 4'd1, 1'b0, 0);
      tick();
      flush = 1; in_valid = 1; in_op = 3'b001; in_op1 = 64'd77;
      @(negedge clk);
      chk("fl_in_ready", in_ready, 0);
      tick();
      flush = 0; in_valid = 0;
      chk("fl_no_accept", eu_op1, 64'd9);
      chk("fl_valid", out_valid, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fl_idle", out_valid, 0);
      end

      // reset while holding a result in DONE
      out_ready = 0;
      issue(3'b001, 64'd3, 64'd4, 8'h00, 8'h55, 4'd9, 1'b0, 0);
      tick();
      chk("rd_valid", out_valid, 1);
      rst_n = 0;
      tick();
      chk("rd_out_valid", out_valid, 0);
      chk("rd_wb_value", wb_value, 0);
      chk("rd_wb_addr", wb_addr, 0);
      chk("rd_eu_op1", eu_op1, 0);
      chk("rd_in_ready", in_ready, 0);
      rst_n = 1; out_ready = 1;
      @(negedge clk);
      chk("rd_rel_ready", in_ready, 1);
      chk("rd_no_valid", out_valid, 0);
      tick();

      // randomized ops with random backpressure
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  op;
         logic [63:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         out_ready = 1'($urandom_range(0, 1));
         issue(op, a, b, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1);
         for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
         end
         if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
      end
      out_ready = 1;
      tick(); tick();
      chk("redirect_count", 64'(rcnt), 64'(exp_rcnt));
      chk("sb_left", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ex_sequencer.md
EX_SEQUENCER -- requirements
Module: ex_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, execute cycles for multiply (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 4, width of latency counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  issue handshake from decode.
REQ-006 in_op  input  3  opcode: 001 add, 010 mul, 100 xor, 011 inc, 110 cmp, 111 branch, other nop.
REQ-007 in_op1, in_op2  input  64 each  operands; in_pc, in_addr  input  8 each; in_rd  input  4; in_flag  input  1.
REQ-008 flush  input  1  abandon in-flight op.
REQ-009 eu_op  output  3; eu_op1, eu_op2  output  64; eu_pc, eu_addr  output  8; eu_rd  output  4: held operands to execution unit.
REQ-010 eu_value  input  64; eu_branch_pc  input  8: execution unit results.
REQ-011 out_valid / out_ready  output / input  1 / 1  writeback handshake.
REQ-012 wb_value  output  64; wb_rd  output  4; wb_addr  output  8; wb_ctrl  output  2.
REQ-013 redirect_valid  output  1; redirect_pc  output  8: taken-branch redirect.
REQ-014 perf_busy, perf_stall  output  32 each  performance counters.

Function
REQ-015 SHALL implement states IDLE, EXEC, DONE.
REQ-016 in_ready SHALL be 1 in IDLE, or in DONE while out_ready=1, and 0 whenever flush=1.
REQ-017 Accept (in_valid & in_ready) SHALL latch all in_* fields into eu_* registers and flag register, go to EXEC, load counter with (op==010 ? MUL_LAT-1 : 0).
REQ-018 eu_* outputs SHALL hold stable from accept edge until next accept or reset (multicycle path for mul).
REQ-019 In EXEC with counter nonzero: decrement; with counter zero: capture eu_value into wb_value, eu_rd into wb_rd, eu_addr into wb_addr, op[1:0] into wb_ctrl, go to DONE.
REQ-020 Latency: non-mul out_valid rises 1 edge after accept edge; mul rises MUL_LAT edges after accept edge.
REQ-021 out_valid SHALL equal state==DONE; wb_* SHALL not change while out_valid=1 and out_ready=0.
REQ-022 DONE with out_ready=1 and in_valid=0: go IDLE; with in_valid=1: accept new op same edge, go EXEC (back-to-back).
REQ-023 Branch (op 111) with latched flag=1: at capture edge redirect_valid SHALL pulse exactly one cycle, redirect_pc=eu_branch_pc; wb_ctrl SHALL be 00.
REQ-024 Branch with flag=0 and nop SHALL complete with wb_ctrl=00, wb_value=0, no redirect.
REQ-025 flush=1 SHALL force IDLE next edge from any state, suppress capture and redirect, accept nothing that edge; flush wins over in_valid and out_ready.
REQ-026 Counter SHALL not wrap; MUL_LAT=1 SHALL make mul timing equal non-mul.

Reset
REQ-027 rst_n=0 at edge SHALL set state IDLE, counter 0, out_valid 0, redirect_valid 0, all wb_*, eu_*, redirect_pc, perf_* to 0.
REQ-028 Reset mid-EXEC or mid-DONE SHALL drop the op with no out_valid and no redirect afterward.
REQ-029 in_ready SHALL be 0 during reset cycle, 1 the cycle after rst_n rises.

Configuration
REQ-030 With EX_SEQ_PERF_EN defined: perf_busy SHALL count cycles in EXEC or DONE, perf_stall cycles with out_valid=1 and out_ready=0, both saturating at 0xFFFFFFFF.
REQ-031 Without EX_SEQ_PERF_EN: perf_busy and perf_stall ports SHALL remain and be constant 0; no counter logic.

Verification
REQ-032 Add: accept op 001, op1=5, op2=7, eu_value=12, out_ready=1 -> out_valid 1 edge later, wb_value=12, wb_ctrl=01.
REQ-033 Mul MUL_LAT=3: accept op 010, op1=6, op2=7 -> eu_op1/eu_op2 stable 3 cycles, out_valid 3 edges after accept, wb_value=42.
REQ-034 Backpressure: out_ready=0 for 4 cycles in DONE -> wb_value held, in_ready=0, perf_stall=4 (macro on); then out_ready=1 with in_valid=1 -> back-to-back accept.
REQ-035 Branch: op 111, flag=1, pc=0x10, addr=0x04, eu_branch_pc=0x14 -> one-cycle redirect_valid, redirect_pc=0x14, wb_ctrl=00; flag=0 -> no redirect.
REQ-036 Flush mid-mul (cycle 2 of 3) with in_valid=1 -> IDLE, no out_valid, no accept that edge.
REQ-037 rst_n=0 in DONE -> all outputs 0 next cycle, in_ready=1 cycle after release.
